sequencer_fsa_gen: RTL and testbench

Parametrised instruction sequencer for the relay computer: a one-hot ring of `NUM_STATES` states that drives the per-step control lines of the datapath. Generalises the fixed 24-state sequencer:
- state count is a parameter;
- early-termination (abort) points are a parameter mask;
- adds run/halt control, a tick enable and boundary pulses.

It sits between the clock/tick generator and the control-line decode.

---
 rtl/sequencer_pkg.sv | 14 +
 rtl/seq_step_gate.sv | 29 ++
 rtl/sequencer_fsa_gen.sv | 97 +++++++++
 tb/tb_sequencer_fsa_gen.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/sequencer_pkg.sv
// Shared defaults and index types for the relay-computer instruction sequencer.
package sequencer_pkg;

  localparam int unsigned SEQ_NUM_STATES_DEF = 24;
  // Abort points at states 8, 10, 12 and 14.
  localparam logic [63:0] SEQ_ABORT_MASK_DEF = 64'h0000_0000_0000_5500;

  localparam int unsigned SEQ_IDX_W = $clog2(SEQ_NUM_STATES_DEF);
  typedef logic [SEQ_IDX_W-1:0] seq_idx_t;

  localparam int unsigned SEQ_IDLE  = 0;
  localparam int unsigned SEQ_FIRST = 1;

endpackage

// File: rtl/seq_step_gate.sv
// Single-step gate: latches a rising edge of step and releases one tick per pulse.
module seq_step_gate (
  input  logic clk_i,
  input  logic reset_i,
  input  logic tick_i,
  input  logic step_i,
  output logic adv_o
);

  logic step_q, step_ok_q, step_ok_d;

  // A new edge arms the latch even in the cycle that consumes the previous one.
  always_comb begin
    step_ok_d = (step_i & ~step_q) | (step_ok_q & ~tick_i);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      step_q    <= 1'b0;
      step_ok_q <= 1'b0;
    end else begin
      step_q    <= step_i;
      step_ok_q <= step_ok_d;
    end
  end

  assign adv_o = tick_i & step_ok_q;

endmodule

// File: rtl/sequencer_fsa_gen.sv
// Parametrised one-hot instruction sequencer with run/halt, abort points and tick enable.
// Defining SEQ_FSA_STEP_EN gates every advance with a single-step pulse on step.
module sequencer_fsa_gen
  import sequencer_pkg::*;
#(
  parameter int unsigned NUM_STATES = SEQ_NUM_STATES_DEF,
  parameter logic [63:0] ABORT_MASK = SEQ_ABORT_MASK_DEF
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          tick,
  input  logic                          run,
  input  logic                          halt_req,
  input  logic                          abort,
  input  logic                          step,
  output logic [NUM_STATES-2:0]         fsm_out,
  output logic [$clog2(NUM_STATES)-1:0] state_idx,
  output logic                          instr_start,
  output logic                          instr_done,
  output logic                          halted
);

  localparam int unsigned IdxW = $clog2(NUM_STATES);
  localparam int unsigned FsmW = NUM_STATES - 1;
  localparam logic [IdxW-1:0] IdleIdx  = IdxW'(SEQ_IDLE);
  localparam logic [IdxW-1:0] FirstIdx = IdxW'(SEQ_FIRST);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(NUM_STATES - 1);

  logic            adv;
  logic [IdxW-1:0] state_q, state_d;
  logic [FsmW-1:0] fsm_q, fsm_d;
  logic            start_q, start_d, done_q, done_d, halted_q, halted_d;
  logic [5:0]      mask_idx;
  logic            abort_pt;

`ifdef SEQ_FSA_STEP_EN
  seq_step_gate u_step_gate (
    .clk_i   (clock),
    .reset_i (reset),
    .tick_i  (tick),
    .step_i  (step),
    .adv_o   (adv)
  );
`else
  logic unused_step;
  assign unused_step = step;
  assign adv         = tick;
`endif

  // Mask bits for idle and the final state never count as abort points.
  assign mask_idx = 6'(state_q);
  assign abort_pt = ABORT_MASK[mask_idx] && (state_q != IdleIdx) && (state_q != LastIdx);

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    if (adv) begin
      if (state_q == IdleIdx) begin
        state_d = run ? FirstIdx : IdleIdx;
      end else if (abort_pt && abort) begin
        state_d = halt_req ? IdleIdx : FirstIdx;
        done_d  = 1'b1;
      end else if (state_q == LastIdx) begin
        state_d = (halt_req || !run) ? IdleIdx : FirstIdx;
        done_d  = 1'b1;
      end else begin
        state_d = state_q + 1'b1;
      end
    end
    start_d  = adv && (state_d == FirstIdx);
    halted_d = (state_d == IdleIdx);
    fsm_d    = halted_d ? '0 : (FsmW'(1) << (state_d - 1'b1));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IdleIdx;
      fsm_q    <= '0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      halted_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      fsm_q    <= fsm_d;
      start_q  <= start_d;
      done_q   <= done_d;
      halted_q <= halted_d;
    end
  end

  assign fsm_out     = fsm_q;
  assign state_idx   = state_q;
  assign instr_start = start_q;
  assign instr_done  = done_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_sequencer_fsa_gen.sv
// Self-checking bench for sequencer_fsa_gen at default parameters.
module tb_sequencer_fsa_gen;
  import sequencer_pkg::*;

  localparam int N = 24;

  logic clock = 1'b0;
  logic reset, tick, run, halt_req, abort, step;
  logic [N-2:0] fsm_out;
  seq_idx_t     state_idx;
  logic         instr_start, instr_done, halted;

  sequencer_fsa_gen dut (
    .clock       (clock),
    .reset       (reset),
    .tick        (tick),
    .run         (run),
    .halt_req    (halt_req),
    .abort       (abort),
    .step        (step),
    .fsm_out     (fsm_out),
    .state_idx   (state_idx),
    .instr_start (instr_start),
    .instr_done  (instr_done),
    .halted      (halted)
  );

  always #5 clock = ~clock;

  typedef struct {
    int    idx;
    bit    start;
    bit    done;
    bit    hlt;
    string tag;
  } exp_t;

  typedef struct {
    bit rst, tck, rn, hr, ab;
    int idx;
    bit start, done, hlt;
  } vec_t;

  exp_t sb_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  task automatic check_out();
    exp_t e;
    logic [N-2:0] e_fsm;
    e = sb_q.pop_front();
    e_fsm = (e.idx == 0) ? '0 : ((N-1)'(1) << (e.idx - 1));
    tests_run++;
    if (state_idx !== seq_idx_t'(e.idx) || fsm_out !== e_fsm || instr_start !== e.start ||
        instr_done !== e.done || halted !== e.hlt) begin
      tests_failed++;
      $display("FAIL %s: got idx=%0d fsm=%h start=%b done=%b halted=%b, want idx=%0d fsm=%h start=%b done=%b halted=%b",
               e.tag, state_idx, fsm_out, instr_start, instr_done, halted,
               e.idx, e_fsm, e.start, e.done, e.hlt);
    end
  endtask

  task automatic cycle(input bit r, input bit t, input bit rn, input bit h, input bit a,
                       input bit s, input int ei, input bit es, input bit ed, input bit eh,
                       input string tag);
    exp_t e;
    reset = r; tick = t; run = rn; halt_req = h; abort = a; step = s;
    e.idx = ei; e.start = es; e.done = ed; e.hlt = eh; e.tag = tag;
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    check_out();
  endtask

  task automatic walk(input int from, input int to, input bit h, input string tag);
    for (int k = from; k <= to; k++) cycle(0, 1, 1, h, 0, 0, k, 0, 0, 0, tag);
  endtask

  vec_t tbl[14];

  initial begin
    reset = 1'b1; tick = 1'b0; run = 1'b0; halt_req = 1'b0; abort = 1'b0; step = 1'b0;

    //            rst tck rn hr ab idx st dn hl
    tbl[0]  = '{0, 1, 0, 0, 0, 0, 0, 0, 1};  // idle without run
    tbl[1]  = '{0, 0, 1, 0, 0, 0, 0, 0, 1};  // no tick, no exit
    tbl[2]  = '{0, 1, 1, 0, 0, 1, 1, 0, 0};  // leave idle
    tbl[3]  = '{0, 0, 1, 0, 0, 1, 0, 0, 0};
    tbl[4]  = '{0, 1, 1, 0, 0, 2, 0, 0, 0};
    tbl[5]  = '{0, 0, 1, 0, 0, 2, 0, 0, 0};
    tbl[6]  = '{0, 1, 1, 0, 1, 3, 0, 0, 0};  // abort in non-mask state ignored
    tbl[7]  = '{0, 1, 1, 0, 0, 4, 0, 0, 0};
    tbl[8]  = '{0, 1, 1, 1, 0, 5, 0, 0, 0};  // halt mid-instruction ignored
    tbl[9]  = '{0, 1, 1, 0, 0, 6, 0, 0, 0};
    tbl[10] = '{0, 1, 1, 0, 0, 7, 0, 0, 0};
    tbl[11] = '{0, 1, 1, 0, 0, 8, 0, 0, 0};
    tbl[12] = '{0, 1, 1, 0, 1, 1, 1, 1, 0};  // abort at state 8
    tbl[13] = '{0, 1, 1, 0, 0, 2, 0, 0, 0};

    cycle(1, 1, 1, 0, 0, 0, 0, 0, 0, 1, "reset0");
    cycle(1, 1, 1, 0, 0, 0, 0, 0, 0, 1, "reset1");

`ifdef SEQ_FSA_STEP_EN
    cycle(0, 1, 1, 0, 0, 0, 0, 0, 0, 1, "no_step");
    for (int n = 1; n <= 3; n++) begin
      cycle(0, 1, 1, 0, 0, 1, n - 1, 0, 0, n == 1, "step_arm");
      cycle(0, 1, 1, 0, 0, 0, n, n == 1, 0, 0, "step_adv");
      cycle(0, 1, 1, 0, 0, 0, n, 0, 0, 0, "step_hold");
    end
    cycle(0, 1, 1, 0, 0, 0, 3, 0, 0, 0, "step_hold_end");
`else
    for (int i = 0; i < 14; i++)
      cycle(tbl[i].rst, tbl[i].tck, tbl[i].rn, tbl[i].hr, tbl[i].ab, 0,
            tbl[i].idx, tbl[i].start, tbl[i].done, tbl[i].hlt, $sformatf("vec%0d", i));

    walk(3, N - 1, 0, "walk");
    cycle(0, 1, 1, 0, 0, 0, 1, 1, 1, 0, "wrap");

    walk(2, N - 1, 0, "full");
    cycle(0, 1, 1, 0, 0, 0, 1, 1, 1, 0, "full_wrap");

    walk(2, 9, 0, "to9");
    cycle(0, 1, 1, 0, 1, 0, 10, 0, 0, 0, "abort_s9");
    cycle(0, 1, 1, 0, 1, 0, 1, 1, 1, 0, "abort_s10");
    walk(2, 11, 0, "to11");
    cycle(0, 1, 1, 0, 1, 0, 12, 0, 0, 0, "abort_s11");
    cycle(0, 1, 1, 1, 1, 0, 0, 0, 1, 1, "halt_abort12");

    cycle(0, 1, 1, 0, 0, 0, 1, 1, 0, 0, "rerun");
    walk(2, 5, 0, "to5");
    walk(6, N - 1, 1, "halt_pending");
    cycle(0, 1, 1, 1, 0, 0, 0, 0, 1, 1, "halt_end");
    cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, "idle_hold");

    cycle(0, 1, 1, 0, 0, 0, 1, 1, 0, 0, "rerun2");
    walk(2, N - 1, 0, "to_last");
    cycle(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, "run_low_end");

    cycle(0, 1, 1, 0, 0, 0, 1, 1, 0, 0, "rerun3");
    walk(2, 17, 0, "to17");
    cycle(1, 1, 1, 0, 0, 0, 0, 0, 0, 1, "reset_mid");
    cycle(1, 1, 1, 0, 0, 0, 0, 0, 0, 1, "reset_hold");
    cycle(0, 1, 1, 0, 0, 0, 1, 1, 0, 0, "restart");

    cycle(0, 0, 1, 0, 0, 1, 1, 0, 0, 0, "step_ignored");
    cycle(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, "step_ignored2");
    cycle(0, 1, 1, 0, 0, 0, 2, 0, 0, 0, "after_step");
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
